data_mem_param: RTL and testbench
=================================

Name: data_mem_param

Overview:
- Parametrised single-pointer data memory for the CSE141L processor datapath: one shared address for reads and writes, with configurable data width, depth and read latency.
- Replaces the fixed 8x256 single-cycle-reset memory with a sequenced clear engine. After reset, the engine walks every location over DEPTH cycles and plants up to two seed constants, signalling Busy throughout.
- Sits between the ALU/address path and the register-file writeback mux.

Parameters:
- DW, 8, data width in bits
- AW, 8, address width in bits
- DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**AW
- READ_LATENCY, 0, 0 = combinational read; 1 = registered read with RdValid
- CLEAR_ON_RESET, 1, 1 = run the clear/seed sequence after reset; 0 = contents preserved across reset
- SEED0_ADDR, 16, address of first seed constant
- SEED0_VAL, 254, value of first seed constant (DW bits)
- SEED1_ADDR, 244, address of second seed constant
- SEED1_VAL, 5, value of second seed constant; a seed whose address is >= DEPTH is ignored

Ports:
- Clk  input  1  clock, all state updates on posedge
- Reset  input  1  synchronous, active-high reset
- WriteEn  input  1  write strobe, sampled at posedge
- ReadEn  input  1  read request (used only when READ_LATENCY=1)
- DataAddress  input  AW  shared read/write pointer
- DataIn  input  DW  write data
- DataOut  output  DW  read data
- RdValid  output  1  DataOut valid strobe (READ_LATENCY=1); tied 1 when idle in mode 0
- Busy  output  1  clear sequence in progress; the memory port is unavailable

Behaviour:
- Reset is synchronous, active-high, on clock Clk.
- States: CLEAR, IDLE.
  - Reset=1 forces state=CLEAR (CLEAR_ON_RESET=1) or IDLE (CLEAR_ON_RESET=0), clr_ptr=0, DataOut reg=0, RdValid=0.
  - Busy reset value is 1 if CLEAR_ON_RESET=1, else 0.
- CLEAR state, each cycle with Reset=0:
  - Writes Core[clr_ptr] = SEEDn_VAL if clr_ptr==SEEDn_ADDR, else 0. SEED0 wins if both seed addresses are equal.
  - clr_ptr increments by 1.
  - At the edge that writes clr_ptr==DEPTH-1, the block goes to IDLE and Busy falls.
  - Busy is therefore high for exactly DEPTH cycles after Reset deasserts.
- During CLEAR: WriteEn and ReadEn are ignored, no user write occurs, RdValid=0, DataOut=0 in both modes.
- Reset reasserted mid-CLEAR restarts the sequence from clr_ptr=0.
- IDLE write: if WriteEn=1 and DataAddress<DEPTH, then Core[DataAddress] <= DataIn at posedge. Writes to addresses >= DEPTH are dropped silently.
- READ_LATENCY=0 (combinational read):
  - DataOut = Core[DataAddress] combinationally; address >= DEPTH reads 0.
  - Read-during-write to the same address shows old data until the edge, new data after it.
  - RdValid = ~Busy.
- READ_LATENCY=1 (registered read):
  - On a posedge with ReadEn=1 in IDLE, DataOut <= Core[DataAddress] (0 if out of range) and RdValid <= 1. Otherwise RdValid <= 0 and DataOut holds.
  - Read-first: a simultaneous write and read to the same address returns the pre-write value; the written value is visible on the next read.
- Clock-enable-free design: no gating. clr_ptr width is AW+1 so that DEPTH=2**AW terminates without wrap.
- Reset has no effect on memory contents except through the CLEAR sequence.

Test Plan:
- Default params, Reset 2 cycles then released -> Busy=1 for exactly 256 cycles, then 0. Afterwards address 16 reads 254, address 244 reads 5, addresses 0, 15, 17 and 255 read 0.
- After clear, WriteEn=1 with address 0x20 and data 0xA5, then a read of 0x20 -> DataOut=0xA5 (mode 0: same cycle after the edge; mode 1: RdValid and 0xA5 one cycle after ReadEn).
- READ_LATENCY=1, same-cycle WriteEn+ReadEn to 0x30 (old 0x11, new 0x22) -> DataOut=0x11 with RdValid=1. A following ReadEn returns 0x22.
- Reset pulsed at cycle 100 of CLEAR, preceded by a user write of 0x7 to address 200 before the reset -> Busy stays high 256 cycles from the second release. Address 200 reads 0. WriteEn during Busy to address 5 has no effect; address 5 reads 0.
- DEPTH=100, AW=8: write 0x3C to address 150 -> dropped, read of 150 returns 0. Busy lasts 100 cycles. SEED1 (addr 244) is ignored, SEED0 at 16 = 254.
- CLEAR_ON_RESET=0: write 0x5A to address 3, pulse Reset -> Busy stays 0, address 3 still reads 0x5A, and RdValid/DataOut reg are 0 immediately after reset.

Source files
------------

// File: rtl/data_mem_param.sv
// data_mem_param: single-pointer data memory with a post-reset clear/seed engine.
// Latency: READ_LATENCY=0 -> combinational read; READ_LATENCY=1 -> one cycle, qualified by RdValid.
// Backpressure: none; Busy high means the port is owned by the clear engine and user accesses are ignored.
//
// Ports:
//   Clk, Reset          - clock and synchronous active-high reset
//   WriteEn, DataIn     - write strobe and data, applied at DataAddress in IDLE
//   ReadEn              - read request (registered-read build only)
//   DataAddress         - shared read/write pointer
//   DataOut, RdValid    - read data and its valid strobe
//   Busy                - clear/seed sequence in progress
module data_mem_param #(
  parameter int DW             = 8,
  parameter int AW             = 8,
  parameter int DEPTH          = 256,
  parameter int READ_LATENCY   = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter int SEED0_ADDR     = 16,
  parameter int SEED0_VAL      = 254,
  parameter int SEED1_ADDR     = 244,
  parameter int SEED1_VAL      = 5
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          WriteEn,
  input  logic          ReadEn,
  input  logic [AW-1:0] DataAddress,
  input  logic [DW-1:0] DataIn,
  output logic [DW-1:0] DataOut,
  output logic          RdValid,
  output logic          Busy
);

  // Array index width sized to DEPTH; the range check on the full address
  // runs first, so dropping the upper address bits here cannot alias.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LAST_PTR = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   SEED0_A  = (AW+1)'(SEED0_ADDR);
  localparam logic [AW:0]   SEED1_A  = (AW+1)'(SEED1_ADDR);
  localparam logic [DW-1:0] SEED0_V  = DW'(SEED0_VAL);
  localparam logic [DW-1:0] SEED1_V  = DW'(SEED1_VAL);
  // A seed placed outside the populated range is simply never planted.
  localparam bit SEED0_EN = (SEED0_ADDR >= 0) && (SEED0_ADDR < DEPTH);
  localparam bit SEED1_EN = (SEED1_ADDR >= 0) && (SEED1_ADDR < DEPTH);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  logic [DW-1:0] core [DEPTH];

  state_t        state_q, state_d;
  // One bit wider than the address so DEPTH == 2**AW finishes without wrapping.
  logic [AW:0]   clr_ptr, clr_ptr_d;
  logic          clr_we;
  logic [DW-1:0] clr_dat;

  logic          addr_ok;
  logic [IW-1:0] addr_idx;
  logic [IW-1:0] clr_idx;
  logic [DW-1:0] rd_word;

  assign addr_ok  = ({1'b0, DataAddress} < DEPTH_W);
  assign addr_idx = DataAddress[IW-1:0];
  assign clr_idx  = clr_ptr[IW-1:0];
  assign rd_word  = addr_ok ? core[addr_idx] : '0;
  assign Busy     = (state_q == S_CLEAR);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RST_STATE;
      clr_ptr <= '0;
    end else begin
      state_q <= state_d;
      clr_ptr <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr;
    clr_we    = 1'b0;
    clr_dat   = '0;
    case (state_q)
      S_CLEAR: begin
        clr_we    = 1'b1;
        clr_ptr_d = clr_ptr + (AW+1)'(1);
        // SEED0 is tested first so it takes priority on a shared address.
        if (SEED0_EN && (clr_ptr == SEED0_A)) begin
          clr_dat = SEED0_V;
        end else if (SEED1_EN && (clr_ptr == SEED1_A)) begin
          clr_dat = SEED1_V;
        end
        if (clr_ptr == LAST_PTR) begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  // Memory array has no reset; contents change only through the clear
  // engine or an in-range user write while idle.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (clr_we) begin
        core[clr_idx] <= clr_dat;
      end else if ((state_q == S_IDLE) && WriteEn && addr_ok) begin
        core[addr_idx] <= DataIn;
      end
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb_rd
      wire unused_rden = ReadEn;
      assign DataOut = Busy ? '0 : rd_word;
      assign RdValid = ~Busy;
    end else begin : g_reg_rd
      logic [DW-1:0] dout_q;
      logic          rdv_q;
      // Read samples the array before this edge's write lands: read-first.
      always_ff @(posedge Clk) begin
        if (Reset) begin
          dout_q <= '0;
          rdv_q  <= 1'b0;
        end else if ((state_q == S_IDLE) && ReadEn) begin
          dout_q <= rd_word;
          rdv_q  <= 1'b1;
        end else begin
          rdv_q  <= 1'b0;
        end
      end
      assign DataOut = dout_q;
      assign RdValid = rdv_q;
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_param.sv
// tb_data_mem_param: directed bench over four builds of data_mem_param.
// Instances: 0 default comb read, 1 registered read, 2 DEPTH=100, 3 no-clear registered read.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled there too.
module tb_data_mem_param;

  logic       clk;
  logic [3:0] rst, we, re;
  logic [7:0] addr, din;
  logic [7:0] dout [4];
  logic [3:0] rdv, busy;

  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_param #(.READ_LATENCY(0)) u_m0 (
    .Clk(clk), .Reset(rst[0]), .WriteEn(we[0]), .ReadEn(re[0]),
    .DataAddress(addr), .DataIn(din), .DataOut(dout[0]), .RdValid(rdv[0]), .Busy(busy[0]));

  data_mem_param #(.READ_LATENCY(1)) u_m1 (
    .Clk(clk), .Reset(rst[1]), .WriteEn(we[1]), .ReadEn(re[1]),
    .DataAddress(addr), .DataIn(din), .DataOut(dout[1]), .RdValid(rdv[1]), .Busy(busy[1]));

  data_mem_param #(.DEPTH(100), .READ_LATENCY(0)) u_m2 (
    .Clk(clk), .Reset(rst[2]), .WriteEn(we[2]), .ReadEn(re[2]),
    .DataAddress(addr), .DataIn(din), .DataOut(dout[2]), .RdValid(rdv[2]), .Busy(busy[2]));

  data_mem_param #(.READ_LATENCY(1), .CLEAR_ON_RESET(0)) u_m3 (
    .Clk(clk), .Reset(rst[3]), .WriteEn(we[3]), .ReadEn(re[3]),
    .DataAddress(addr), .DataIn(din), .DataOut(dout[3]), .RdValid(rdv[3]), .Busy(busy[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Combinational read on an instance in the comb-read build.
  task automatic rd0(input int inst, input logic [7:0] a, input logic [7:0] exp, input string tag);
    addr = a;
    #1;
    chk(tag, dout[inst], exp);
  endtask

  // One-cycle registered read: expect RdValid and data after the edge.
  task automatic rd1(input int inst, input logic [7:0] a, input logic [7:0] exp, input string tag);
    addr = a;
    re[inst] = 1'b1;
    tick();
    re[inst] = 1'b0;
    chk({tag, "_vld"}, rdv[inst], 1);
    chk(tag, dout[inst], exp);
  endtask

  task automatic wr(input int inst, input logic [7:0] a, input logic [7:0] d);
    addr = a;
    din  = d;
    we[inst] = 1'b1;
    tick();
    we[inst] = 1'b0;
  endtask

  initial begin
    int cnt;
    int fall2;
    rst  = 4'hF;
    we   = 4'h0;
    re   = 4'h0;
    addr = 8'h00;
    din  = 8'h00;
    tick();
    tick();

    // Reset state
    chk("rst_busy0", busy[0], 1);
    chk("rst_busy2", busy[2], 1);
    chk("rst_busy3", busy[3], 0);
    chk("rst_rdv1", rdv[1], 0);
    chk("rst_dout1", dout[1], 0);
    chk("rst_rdv0", rdv[0], 0);
    rst = 4'h0;

    // Clear sequence length: 256 for default, 100 for DEPTH=100
    cnt   = 0;
    fall2 = 0;
    while (busy[0] && cnt < 1000) begin
      tick();
      cnt++;
      if (!busy[2] && fall2 == 0) fall2 = cnt;
      if (cnt == 10) begin
        chk("clr_rdv0", rdv[0], 0);
        chk("clr_dout0", dout[0], 0);
        chk("clr_rdv1", rdv[1], 0);
      end
    end
    chk("busy_len0", cnt, 256);
    chk("busy_len2", fall2, 100);
    chk("busy1_done", busy[1], 0);
    chk("rdv0_idle", rdv[0], 1);

    // Seeds and zeroed locations
    rd0(0, 8'd16, 8'd254, "seed0");
    rd0(0, 8'd244, 8'd5, "seed1");
    rd0(0, 8'd0, 8'd0, "zero_0");
    rd0(0, 8'd15, 8'd0, "zero_15");
    rd0(0, 8'd17, 8'd0, "zero_17");
    rd0(0, 8'd255, 8'd0, "zero_255");
    rd1(1, 8'd16, 8'd254, "m1_seed0");
    rd1(1, 8'd244, 8'd5, "m1_seed1");

    // Comb-read write: old data before the edge, new after
    addr = 8'h20;
    din  = 8'hA5;
    we[0] = 1'b1;
    #1;
    chk("rdw_old", dout[0], 8'h00);
    tick();
    we[0] = 1'b0;
    chk("rdw_new", dout[0], 8'hA5);

    // Registered read of a written word, then RdValid drops and data holds
    wr(1, 8'h20, 8'hA5);
    rd1(1, 8'h20, 8'hA5, "m1_wr_rd");
    tick();
    chk("m1_vld_drop", rdv[1], 0);
    chk("m1_hold", dout[1], 8'hA5);

    // Read-first on simultaneous write+read
    wr(1, 8'h30, 8'h11);
    addr = 8'h30;
    din  = 8'h22;
    we[1] = 1'b1;
    re[1] = 1'b1;
    tick();
    we[1] = 1'b0;
    re[1] = 1'b0;
    chk("rf_vld", rdv[1], 1);
    chk("rf_old", dout[1], 8'h11);
    rd1(1, 8'h30, 8'h22, "rf_new");

    // DEPTH=100: out-of-range write dropped, no aliasing, seed1 ignored
    wr(2, 8'd150, 8'h3C);
    rd0(2, 8'd150, 8'h00, "d100_oor");
    rd0(2, 8'd22, 8'h00, "d100_alias");
    rd0(2, 8'd16, 8'd254, "d100_seed0");
    rd0(2, 8'd116, 8'h00, "d100_seed1_alias");
    wr(2, 8'd99, 8'h77);
    rd0(2, 8'd99, 8'h77, "d100_last");

    // Reset mid-clear restarts the full sequence
    wr(0, 8'd200, 8'h07);
    rd0(0, 8'd200, 8'h07, "pre_rst_200");
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    repeat (100) tick();
    chk("mid_busy", busy[0], 1);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    addr = 8'd5;
    din  = 8'h55;
    we[0] = 1'b1;
    cnt = 0;
    while (busy[0] && cnt < 1000) begin
      tick();
      cnt++;
    end
    we[0] = 1'b0;
    chk("rerun_len", cnt, 256);
    rd0(0, 8'd200, 8'h00, "rerun_200");
    rd0(0, 8'd5, 8'h00, "busy_wr_5");
    rd0(0, 8'd16, 8'd254, "rerun_seed0");

    // No-clear build: contents survive reset, read regs cleared
    wr(3, 8'd3, 8'h5A);
    rd1(3, 8'd3, 8'h5A, "nc_pre");
    rst[3] = 1'b1;
    tick();
    chk("nc_rst_busy", busy[3], 0);
    chk("nc_rst_vld", rdv[3], 0);
    chk("nc_rst_dout", dout[3], 0);
    rst[3] = 1'b0;
    tick();
    chk("nc_busy", busy[3], 0);
    rd1(3, 8'd3, 8'h5A, "nc_keep");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
